output_pack_writer: RTL and testbench
=====================================

Name: output_pack_writer

Overview:
- Sits directly downstream of the requantize controller.
- Consumes the per-channel int8 outputs (valid/row/col/data, one per channel per cycle, no backpressure) and packs them into 32-bit activation words, four consecutive columns per word.
- Buffers packed words in small per-channel FIFOs and drains them through one round-robin-arbitrated write port into activation RAM.
- Provides a start/flush/done layer protocol and a sticky overflow flag.

Parameters:
- SA_N, 4, number of input channels (one per requantize lane)
- MAX_N, 16, max rows/cols of an output tile; must be a multiple of 4
- N_BITS, $clog2(MAX_N), row/col index width
- ADDR_WIDTH, 12, activation RAM word-address width
- FIFO_DEPTH, 4, packed-word entries per channel FIFO; power of 2, at least 2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; latches base_addr/ch_stride and enters RUN
- base_addr  in  ADDR_WIDTH  word address of channel 0, row 0, col 0
- ch_stride  in  ADDR_WIDTH  word offset between consecutive channel planes
- flush  in  1  pulse; end of layer, emit partial words and drain
- in_valid  in  [SA_N] x 1  per-channel byte valid
- in_row  in  [SA_N] x N_BITS  output row
- in_col  in  [SA_N] x N_BITS  output column
- in_data  in  [SA_N] x int8_t  requantized activation
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_WIDTH  RAM word address
- mem_wdata  out  32  packed word; byte k holds column 4*w+k
- mem_wstrb  out  4  byte enables
- idle  out  1  state IDLE
- done  out  1  one-cycle pulse on FLUSH to IDLE transition
- overflow  out  1  sticky; a packed word was dropped

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE; all pack registers and FIFOs empty; RR pointer = 0.
  - mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, done=0, overflow=0, idle=1.
- States:
  - IDLE to RUN on start. start also clears overflow and latches base_addr/ch_stride.
  - RUN to FLUSH on flush.
  - FLUSH to IDLE when all pack registers and FIFOs are empty and no write is pending in the output register. done pulses in the cycle idle rises.
  - start while not IDLE is ignored.
- Address computation, per channel ch:
  - waddr = base + ch*ch_stride + in_row*(MAX_N/4) + (in_col>>2), truncated to ADDR_WIDTH.
  - lane = in_col[1:0].
- Pack register, per channel: fields vld, addr, data[31:0], strb[3:0], full. full is set when lane 3 is written.
- Each cycle, per channel, push = pack.vld && (pack.full || (in_valid && waddr != pack.addr) || state==FLUSH). At most one push per channel per cycle.
- Accepted input byte (state RUN or FLUSH):
  - If push, or pack empty: pack is loaded fresh with only that byte's lane.
  - Otherwise: byte is merged into pack; a duplicate lane overwrites its byte and keeps strb.
  - full = (lane==3).
- Input with in_valid in IDLE: dropped, no other effect.
- Flush with same-cycle in_valid: the byte is accepted into the pack and emitted on a later FLUSH cycle.
- Push into a full FIFO: word dropped, overflow set (sticky).
- Latency: a lane-3 byte at cycle t marks full; the word is pushed at the end of t+1; earliest mem_we is at t+3 (FIFO registered head, then registered output).
- Arbiter:
  - Each cycle, grant the first non-empty FIFO starting from RR pointer+1 (mod SA_N).
  - Pop it; register its addr/data/strb onto the mem_* outputs with mem_we=1. RR pointer := granted channel.
  - No grant: mem_we=0, other outputs hold.
- FIFO: simultaneous push and pop on a full FIFO is legal and loses nothing.
- mem_wdata bytes whose strb bit is 0 are 0.

Test Plan:
- Raster fill: start base=0x100, ch_stride=4; ch0 feeds row0 cols 0..3 with data 1,2,3,4 → one write, addr 0x100, wdata 0x04030201, wstrb 0xF, at cycle (lane-3 cycle)+3.
- Partial plus flush: ch2 feeds row1 cols 4,5 (0x11,0x22), then flush → write addr 0x100+8+4+1=0x10D, wdata 0x00002211, wstrb 0x3; done pulses and idle returns to 1.
- Address change: ch1 feeds col0 then row2 col8 → first word pushed with wstrb 0x1; second word held until flush, wstrb 0x1 at addr base+4+8+2.
- Contention: all 4 channels complete a word in the same cycle → 4 writes on consecutive cycles in RR order 1,2,3,0 (pointer reset 0); no overflow.
- Overflow: FIFO_DEPTH=2, continuous lane-3-only inputs on all 4 channels for 16 cycles → overflow=1, stays set until next start, which clears it.
- Async reset mid-RUN with words pending → mem_we drops immediately, idle=1, no write after release; IDLE inputs produce no writes.

Source files
------------

// File: rtl/output_pack_writer.sv
// output_pack_writer: packs per-channel int8 results into 32-bit words, buffers them in
// per-channel FIFOs and drains them through one round-robin arbitrated RAM write port.
module output_pack_writer #(
   parameter int SA_N       = 4,
   parameter int MAX_N      = 16,
   parameter int N_BITS     = $clog2(MAX_N),
   parameter int ADDR_WIDTH = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [ADDR_WIDTH-1:0]    base_addr,
   input  logic [ADDR_WIDTH-1:0]    ch_stride,
   input  logic                     flush,
   input  logic [SA_N-1:0]          in_valid,
   input  logic [SA_N*N_BITS-1:0]   in_row,
   input  logic [SA_N*N_BITS-1:0]   in_col,
   input  logic [SA_N*8-1:0]        in_data,
   output logic                     mem_we,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_wstrb,
   output logic                     idle,
   output logic                     done,
   output logic                     overflow
);
   localparam int FW = $clog2(FIFO_DEPTH);
   localparam int CW = SA_N > 1 ? $clog2(SA_N) : 1;
   localparam int EW = ADDR_WIDTH + 36;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t                r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_base, r_stride;
   logic [SA_N-1:0]       r_pv, r_pf;
   logic [ADDR_WIDTH-1:0] r_pa [SA_N];
   logic [31:0]           r_pd [SA_N];
   logic [3:0]            r_ps [SA_N];
   logic [EW-1:0]         r_fm [SA_N][FIFO_DEPTH];
   logic [FW-1:0]         r_wp [SA_N];
   logic [FW-1:0]         r_rp [SA_N];
   logic [FW:0]           r_cnt [SA_N];
   logic [CW-1:0]         r_rr;
   logic                  r_we, r_done, r_ovf;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;

   logic [ADDR_WIDTH-1:0] w_waddr [SA_N];
   logic [1:0]            w_lane [SA_N];
   logic [SA_N-1:0]       w_acc, w_push, w_fe, w_ff, w_pop, w_wr;
   logic                  w_gv, w_ovf, w_drained;
   logic [CW-1:0]         w_gi;
   logic [EW-1:0]         w_head;
   int                    w_j;

   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_wstrb = r_wstrb;
   assign idle      = r_state == S_IDLE;
   assign done      = r_done;
   assign overflow  = r_ovf;

   always_comb begin
      w_acc  = '0;
      w_push = '0;
      w_fe   = '0;
      w_ff   = '0;
      for (int c = 0; c < SA_N; c++) begin
         w_waddr[c] = r_base + ADDR_WIDTH'(c) * r_stride
                    + ADDR_WIDTH'(in_row[c*N_BITS +: N_BITS]) * ADDR_WIDTH'(MAX_N / 4)
                    + ADDR_WIDTH'(in_col[c*N_BITS +: N_BITS] >> 2);
         w_lane[c]  = in_col[c*N_BITS +: 2];
         w_fe[c]    = r_cnt[c] == '0;
         w_ff[c]    = r_cnt[c][FW];
         w_acc[c]   = in_valid[c] && r_state != S_IDLE;
         w_push[c]  = r_pv[c] && (r_pf[c] || (in_valid[c] && w_waddr[c] != r_pa[c]) || r_state == S_FLUSH);
      end
   end

   // Scan downwards so the lowest offset from the pointer wins.
   always_comb begin
      w_gv  = 1'b0;
      w_gi  = '0;
      w_pop = '0;
      w_j   = 0;
      for (int k = SA_N; k >= 1; k--) begin
         w_j = (int'(r_rr) + k) % SA_N;
         if (!w_fe[w_j]) begin
            w_gv = 1'b1;
            w_gi = CW'(w_j);
         end
      end
      if (w_gv) w_pop[w_gi] = 1'b1;
      w_wr      = w_push & (~w_ff | w_pop);
      w_head    = r_fm[w_gi][r_rp[w_gi]];
      w_ovf     = |(w_push & w_ff & ~w_pop);
      w_drained = ~|r_pv && &w_fe && !r_we && ~|in_valid;
   end

   always_comb begin
      w_next = r_state;
      if (r_state == S_IDLE && start) w_next = S_RUN;
      else if (r_state == S_RUN && flush) w_next = S_FLUSH;
      else if (r_state == S_FLUSH && w_drained) w_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < SA_N; c++)
         if (w_wr[c]) r_fm[c][r_wp[c]] <= {r_pa[c], r_pd[c], r_ps[c]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_base   <= '0;
         r_stride <= '0;
         r_pv     <= '0;
         r_pf     <= '0;
         r_rr     <= '0;
         r_we     <= 1'b0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         for (int c = 0; c < SA_N; c++) begin
            r_pa[c]  <= '0;
            r_pd[c]  <= '0;
            r_ps[c]  <= '0;
            r_wp[c]  <= '0;
            r_rp[c]  <= '0;
            r_cnt[c] <= '0;
         end
      end else begin
         r_state <= w_next;
         r_done  <= r_state == S_FLUSH && w_next == S_IDLE;
         if (r_state == S_IDLE && start) begin
            r_base   <= base_addr;
            r_stride <= ch_stride;
            r_ovf    <= 1'b0;
         end else if (w_ovf) r_ovf <= 1'b1;
         r_we <= w_gv;
         if (w_gv) begin
            r_rr    <= w_gi;
            r_addr  <= w_head[EW-1:36];
            r_wdata <= w_head[35:4];
            r_wstrb <= w_head[3:0];
         end
         for (int c = 0; c < SA_N; c++) begin
            if (w_acc[c]) begin
               if (w_push[c] || !r_pv[c]) begin
                  r_pd[c] <= '0;
                  r_ps[c] <= '0;
               end
               r_pd[c][{w_lane[c], 3'b000} +: 8] <= in_data[c*8 +: 8];
               r_ps[c][w_lane[c]] <= 1'b1;
               r_pv[c] <= 1'b1;
               r_pa[c] <= w_waddr[c];
               r_pf[c] <= &w_lane[c];
            end else if (w_push[c]) begin
               r_pv[c] <= 1'b0;
               r_pf[c] <= 1'b0;
            end
            if (w_wr[c]) r_wp[c] <= r_wp[c] + 1'b1;
            if (w_pop[c]) r_rp[c] <= r_rp[c] + 1'b1;
            r_cnt[c] <= r_cnt[c] + (FW+1)'(w_wr[c]) - (FW+1)'(w_pop[c]);
         end
      end
   end
endmodule

// File: tb/tb_output_pack_writer.sv
// tb_output_pack_writer: scoreboard bench; a byte-level word assembler predicts RAM writes,
// a forked monitor matches every mem_we against the per-channel expected order.
module tb_output_pack_writer;
   localparam int SA_N = 4;
   localparam int NB   = 4;
   localparam int AW   = 12;

   typedef struct {int ch; logic [AW-1:0] a; logic [31:0] d; logic [3:0] s;} wr_t;

   logic clk = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0;
   logic [AW-1:0] base_addr = '0, ch_stride = '0;
   logic [SA_N-1:0] in_valid = '0;
   logic [SA_N*NB-1:0] in_row = '0, in_col = '0;
   logic [SA_N*8-1:0] in_data = '0;
   logic mem_we, idle, done, overflow;
   logic [AW-1:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0] mem_wstrb;
   logic o2_we, o2_idle, o2_done, o2_overflow;
   logic [AW-1:0] o2_addr;
   logic [31:0] o2_wdata;
   logic [3:0] o2_wstrb;

   int n_cmp = 0, n_err = 0, n_wr = 0, wr_cyc = 0, l3_cyc = 0, cyc = 0;
   int mode = 0;
   bit sb_on = 1'b1;
   wr_t q[$];
   int ch_log[$];
   logic m_open [SA_N];
   logic [AW-1:0] m_addr [SA_N];
   logic [31:0] m_data [SA_N];
   logic [3:0] m_strb [SA_N];
   logic [AW-1:0] m_base = '0, m_stride = '0;
   logic sv [SA_N];
   int srow [SA_N], scol [SA_N];
   logic [7:0] sdat [SA_N];
   logic s_start = 1'b0, s_flush = 1'b0;

   output_pack_writer u_dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .ch_stride(ch_stride),
      .flush(flush), .in_valid(in_valid), .in_row(in_row), .in_col(in_col), .in_data(in_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .idle(idle), .done(done), .overflow(overflow));

   output_pack_writer #(.FIFO_DEPTH(2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .ch_stride(ch_stride),
      .flush(flush), .in_valid(in_valid), .in_row(in_row), .in_col(in_col), .in_data(in_data),
      .mem_we(o2_we), .mem_addr(o2_addr), .mem_wdata(o2_wdata), .mem_wstrb(o2_wstrb),
      .idle(o2_idle), .done(o2_done), .overflow(o2_overflow));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic emit(input int c);
      q.push_back('{c, m_addr[c], m_data[c], m_strb[c]});
      m_open[c] = 1'b0;
   endtask

   task automatic clr();
      for (int c = 0; c < SA_N; c++) begin
         sv[c] = 1'b0; srow[c] = 0; scol[c] = 0; sdat[c] = '0;
      end
      s_start = 1'b0;
      s_flush = 1'b0;
   endtask

   task automatic model_reset();
      mode = 0;
      q.delete();
      for (int c = 0; c < SA_N; c++) m_open[c] = 1'b0;
   endtask

   // One clock of stimulus: drive, predict, advance to #1 past the sampling edge.
   task automatic step();
      logic [AW-1:0] a;
      int lane;
      for (int c = 0; c < SA_N; c++) begin
         in_valid[c] = sv[c];
         in_row[c*NB +: NB] = NB'(srow[c]);
         in_col[c*NB +: NB] = NB'(scol[c]);
         in_data[c*8 +: 8] = sdat[c];
      end
      start = s_start;
      flush = s_flush;
      if (mode == 0) begin
         if (s_start) begin
            mode = 1; m_base = base_addr; m_stride = ch_stride;
         end
      end else begin
         for (int c = 0; c < SA_N; c++) if (sv[c]) begin
            a = AW'(int'(m_base) + c * int'(m_stride) + srow[c] * 4 + scol[c] / 4);
            lane = scol[c] % 4;
            if (lane == 3) l3_cyc = cyc;
            if (m_open[c] && (a != m_addr[c] || mode == 2)) emit(c);
            if (!m_open[c]) begin
               m_open[c] = 1'b1; m_addr[c] = a; m_data[c] = '0; m_strb[c] = '0;
            end
            m_data[c][lane*8 +: 8] = sdat[c];
            m_strb[c][lane] = 1'b1;
            if (lane == 3) emit(c);
         end
         if (s_flush && mode == 1) mode = 2;
         if (mode == 2) for (int c = 0; c < SA_N; c++) if (m_open[c]) emit(c);
      end
      @(posedge clk);
      #1;
      clr();
      in_valid = '0;
      start = 1'b0;
      flush = 1'b0;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_idle(input int maxc);
      bit got;
      got = 1'b0;
      for (int k = 0; k < maxc && !got; k++) begin
         @(negedge clk);
         if (idle) begin
            got = 1'b1;
            chk("done_with_idle", done, 1);
         end
      end
      if (!got) begin
         n_cmp++; n_err++;
         $display("FAIL idle_timeout: idle stayed 0 for %0d cycles, required 1", maxc);
      end
      mode = 0;
      @(posedge clk);
      #1;
      idle_steps(3);
   endtask

   task automatic monitor();
      int hit;
      logic [SA_N-1:0] seen;
      forever begin
         @(negedge clk);
         if (reset && mem_we) n_wr++;
         if (reset && mem_we && sb_on) begin
            hit = -1;
            seen = '0;
            wr_cyc = cyc;
            for (int i = 0; i < q.size(); i++) if (hit < 0) begin
               if (!seen[q[i].ch] && q[i].a == mem_addr) hit = i;
               seen[q[i].ch] = 1'b1;
            end
            if (hit < 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_write: addr %h data %h strb %h matches no pending expected word",
                        mem_addr, mem_wdata, mem_wstrb);
            end else begin
               chk("wdata", mem_wdata, q[hit].d);
               chk("wstrb", {28'd0, mem_wstrb}, {28'd0, q[hit].s});
               ch_log.push_back(q[hit].ch);
               q.delete(hit);
            end
         end
      end
   endtask

   task automatic start_layer(input logic [AW-1:0] b, input logic [AW-1:0] s);
      base_addr = b;
      ch_stride = s;
      s_start = 1'b1;
      step();
   endtask

   task automatic flush_layer();
      s_flush = 1'b1;
      step();
      wait_idle(200);
   endtask

   initial begin
      clr();
      model_reset();
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      chk("rst_idle", idle, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wstrb", mem_wstrb, 0);
      chk("rst_done", done, 0);
      chk("rst_overflow", overflow, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // raster fill then partial word on ch2 and flush
      n_wr = 0;
      start_layer(12'h100, 12'd4);
      for (int k = 0; k < 4; k++) begin
         sv[0] = 1'b1; srow[0] = 0; scol[0] = k; sdat[0] = 8'(k + 1);
         step();
      end
      idle_steps(6);
      chk("raster_writes", n_wr, 1);
      chk("raster_latency", wr_cyc, l3_cyc + 3);
      sv[2] = 1'b1; srow[2] = 1; scol[2] = 4; sdat[2] = 8'h11;
      step();
      sv[2] = 1'b1; srow[2] = 1; scol[2] = 5; sdat[2] = 8'h22;
      step();
      flush_layer();
      chk("partial_drained", q.size(), 0);
      chk("partial_writes", n_wr, 2);

      // address change holds second word until flush
      n_wr = 0;
      start_layer(12'h100, 12'd4);
      sv[1] = 1'b1; srow[1] = 0; scol[1] = 0; sdat[1] = 8'h5A;
      step();
      sv[1] = 1'b1; srow[1] = 2; scol[1] = 8; sdat[1] = 8'hA5;
      step();
      idle_steps(8);
      chk("addrchg_first_only", n_wr, 1);
      chk("addrchg_queue_empty", q.size(), 0);
      flush_layer();
      chk("addrchg_writes", n_wr, 2);

      // contention after reset: RR order 1,2,3,0
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      start_layer(12'h100, 12'd4);
      ch_log.delete();
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < SA_N; c++) begin
            sv[c] = 1'b1; srow[c] = 0; scol[c] = k; sdat[c] = 8'($urandom);
         end
         step();
      end
      idle_steps(10);
      chk("contention_count", ch_log.size(), 4);
      for (int i = 0; i < 4 && i < ch_log.size(); i++) chk("contention_order", ch_log[i], (i + 1) % 4);
      chk("contention_no_ovf", overflow, 0);
      flush_layer();

      // overflow: lane-3-only traffic on all channels
      sb_on = 1'b0;
      start_layer(12'h000, 12'd4);
      for (int k = 0; k < 16; k++) begin
         for (int c = 0; c < SA_N; c++) begin
            sv[c] = 1'b1; srow[c] = 0; scol[c] = 3; sdat[c] = 8'($urandom);
         end
         step();
      end
      chk("ovf_set_depth2", o2_overflow, 1);
      chk("ovf_set_depth4", overflow, 1);
      flush_layer();
      chk("ovf_sticky_depth2", o2_overflow, 1);
      chk("ovf_sticky_depth4", overflow, 1);
      q.delete();
      sb_on = 1'b1;
      start_layer(12'h000, 12'd4);
      chk("ovf_cleared_depth2", o2_overflow, 0);
      chk("ovf_cleared_depth4", overflow, 0);
      flush_layer();

      // async reset with writes in flight, then IDLE inputs
      start_layer(12'h100, 12'd4);
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < SA_N; c++) begin
            sv[c] = 1'b1; srow[c] = 1; scol[c] = k; sdat[c] = 8'($urandom);
         end
         step();
      end
      idle_steps(2);
      chk("pre_reset_we", mem_we, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_we", mem_we, 0);
      chk("async_rst_idle", idle, 1);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      n_wr = 0;
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < SA_N; c++) begin
            sv[c] = 1'b1; srow[c] = 0; scol[c] = 3; sdat[c] = 8'($urandom);
         end
         step();
      end
      idle_steps(10);
      chk("idle_inputs_no_write", n_wr, 0);
      chk("idle_inputs_idle", idle, 1);

      // randomized traffic, one byte at most every other cycle
      start_layer(12'h200, 12'd64);
      for (int i = 0; i < 400; i++) begin
         if (i % 2 == 0 && $urandom_range(3) != 0) begin
            int c;
            c = $urandom_range(SA_N - 1);
            sv[c] = 1'b1; srow[c] = $urandom_range(1); scol[c] = $urandom_range(7); sdat[c] = 8'($urandom);
         end
         step();
      end
      flush_layer();
      chk("random_drained", q.size(), 0);
      chk("random_no_ovf", overflow, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
